// File: rtl/jt49_bus_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jt49_bus_seq : valid/ready register access -> AY-3-8910 BDIR/BC1 cycles  |
// | Optional feature: JT49_ADDR_CACHE_EN (skip address latch on repeat addr) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jt49_bus_seq #(
   parameter int HOLD = 2,
   parameter int GAP  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req,
   input  logic       rnw,
   input  logic [3:0] addr,
   input  logic [7:0] wdata,
   output logic       ready,
   output logic [7:0] rdata,
   output logic       rd_valid,
   output logic       bdir,
   output logic       bc1,
   output logic [7:0] bus_dout,
   input  logic [7:0] psg_din
);

   localparam logic [3:0] C_HOLD_M1 = 4'(HOLD - 1);
   localparam logic [3:0] C_GAP_M1  = 4'(GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_SEP   = 3'd2,
      S_WR    = 3'd3,
      S_RD    = 3'd4,
      S_TAIL  = 3'd5
   } state_t;

   state_t      r_state, w_state_n;
   logic [3:0]  r_cnt, w_cnt_n;
   logic        r_rnw, w_rnw_n;
   logic [3:0]  r_addr, w_addr_n;
   logic [7:0]  r_wdata, w_wdata_n;
   logic        w_accept, w_hit;
   logic        w_ready_n, w_bdir_n, w_bc1_n, w_rd_valid_n;
   logic [7:0]  w_bus_dout_n, w_rdata_n;

`ifdef JT49_ADDR_CACHE_EN
   logic [3:0]  r_last_addr;
   logic        r_cache_vld;

   assign w_hit = r_cache_vld && (addr == r_last_addr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_addr <= 4'd0;
         r_cache_vld <= 1'b0;
      end else if (r_state == S_LATCH && r_cnt == 4'd0) begin
         r_last_addr <= r_addr;
         r_cache_vld <= 1'b1;
      end
   end
`else
   assign w_hit = 1'b0;
`endif

   // ready is only ever high in IDLE or the last TAIL cycle, so accept is safe here
   always_comb begin
      w_accept  = req && ready;
      w_rnw_n   = w_accept ? rnw   : r_rnw;
      w_addr_n  = w_accept ? addr  : r_addr;
      w_wdata_n = w_accept ? wdata : r_wdata;
      w_state_n = r_state;
      w_cnt_n   = r_cnt;

      if (w_accept) begin
         w_cnt_n = C_HOLD_M1;
         if (w_hit)
            w_state_n = rnw ? S_RD : S_WR;
         else
            w_state_n = S_LATCH;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_LATCH: begin
               if (r_cnt == 4'd0) begin
                  w_state_n = S_SEP;
                  w_cnt_n   = 4'd0;
               end else begin
                  w_cnt_n = r_cnt - 4'd1;
               end
            end
            S_SEP: begin
               w_state_n = r_rnw ? S_RD : S_WR;
               w_cnt_n   = C_HOLD_M1;
            end
            S_WR, S_RD: begin
               if (r_cnt == 4'd0) begin
                  w_state_n = S_TAIL;
                  w_cnt_n   = C_GAP_M1;
               end else begin
                  w_cnt_n = r_cnt - 4'd1;
               end
            end
            S_TAIL: begin
               if (r_cnt == 4'd0) begin
                  w_state_n = S_IDLE;
                  w_cnt_n   = 4'd0;
               end else begin
                  w_cnt_n = r_cnt - 4'd1;
               end
            end
            default: begin
               w_state_n = S_IDLE;
               w_cnt_n   = 4'd0;
            end
         endcase
      end

      // Outputs are decoded from the next state so they are registered with it
      w_bdir_n     = 1'b0;
      w_bc1_n      = 1'b0;
      w_bus_dout_n = bus_dout;
      case (w_state_n)
         S_LATCH: begin
            w_bdir_n     = 1'b1;
            w_bc1_n      = 1'b1;
            w_bus_dout_n = {4'b0000, w_addr_n};
         end
         S_WR: begin
            w_bdir_n     = 1'b1;
            w_bus_dout_n = w_wdata_n;
         end
         S_RD: begin
            w_bc1_n      = 1'b1;
            w_bus_dout_n = 8'h00;
         end
         default: ;
      endcase

      w_ready_n    = (w_state_n == S_IDLE) || (w_state_n == S_TAIL && w_cnt_n == 4'd0);
      w_rd_valid_n = (r_state == S_RD) && (r_cnt == 4'd0) && !w_accept;
      w_rdata_n    = w_rd_valid_n ? psg_din : rdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_rnw    <= 1'b0;
         r_addr   <= 4'd0;
         r_wdata  <= 8'd0;
         ready    <= 1'b0;
         bdir     <= 1'b0;
         bc1      <= 1'b0;
         bus_dout <= 8'd0;
         rdata    <= 8'd0;
         rd_valid <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_cnt    <= w_cnt_n;
         r_rnw    <= w_rnw_n;
         r_addr   <= w_addr_n;
         r_wdata  <= w_wdata_n;
         ready    <= w_ready_n;
         bdir     <= w_bdir_n;
         bc1      <= w_bc1_n;
         bus_dout <= w_bus_dout_n;
         rdata    <= w_rdata_n;
         rd_valid <= w_rd_valid_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jt49_bus_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jt49_bus_seq : directed bench for jt49_bus_seq (HOLD=2/GAP=1 and      |
// | HOLD=1/GAP=3 instances); honours JT49_ADDR_CACHE_EN. Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_jt49_bus_seq;

   // Bus codes listed per cycle t0+1.., cycle 1 in the low bits
   localparam logic [15:0] C_WR_FULL = 16'b0000_00_10_10_00_11_11;
   localparam logic [15:0] C_RD_FULL = 16'b0000_00_01_01_00_11_11;
   localparam logic [15:0] C_WR_HIT  = 16'b0000_0000_00_00_10_10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req, rnw;
   logic [3:0] addr;
   logic [7:0] wdata, psg_din;
   logic       ready, rd_valid, bdir, bc1;
   logic [7:0] rdata, bus_dout;

   logic       req_b, rnw_b;
   logic [3:0] addr_b;
   logic [7:0] wdata_b, psg_din_b;
   logic       ready_b, rd_valid_b, bdir_b, bc1_b;
   logic [7:0] rdata_b, bus_dout_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   jt49_bus_seq #(.HOLD(2), .GAP(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
      .ready(ready), .rdata(rdata), .rd_valid(rd_valid), .bdir(bdir), .bc1(bc1),
      .bus_dout(bus_dout), .psg_din(psg_din)
   );

   jt49_bus_seq #(.HOLD(1), .GAP(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .rnw(rnw_b), .addr(addr_b), .wdata(wdata_b),
      .ready(ready_b), .rdata(rdata_b), .rd_valid(rd_valid_b), .bdir(bdir_b), .bc1(bc1_b),
      .bus_dout(bus_dout_b), .psg_din(psg_din_b)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One transaction on u_dut; codes/n give the expected {bdir,bc1} for t0+1..t0+n
   task automatic txn(input logic r, input logic [3:0] a, input logic [7:0] wd,
                      input logic [7:0] din, input logic [15:0] codes, input int n,
                      input logic hold);
      logic [1:0] prev, cur, exp;
      logic       bad;
      check("ready_pre", 8'(ready), 8'd1);
      req = 1'b1; rnw = r; addr = a; wdata = wd; psg_din = 8'h5A;
      prev = 2'b00;
      step();
      if (!hold) req = 1'b0;
      for (int k = 1; k <= n; k++) begin
         exp = codes[2*(k-1) +: 2];
         cur = {bdir, bc1};
         check("code", 8'(cur), 8'(exp));
         check("ready", 8'(ready), 8'(k == n));
         check("rd_valid", 8'(rd_valid), 8'(r && k == n));
         case (exp)
            2'b11:   check("dout_addr", bus_dout, {4'h0, a});
            2'b10:   check("dout_wr", bus_dout, wd);
            2'b01:   check("dout_rd", bus_dout, 8'h00);
            default: ;
         endcase
         bad = (prev == 2'b11 && (cur == 2'b10 || cur == 2'b01)) ||
               (cur == 2'b11 && (prev == 2'b10 || prev == 2'b01)) ||
               (prev != 2'b00 && cur != 2'b00 && prev != cur);
         check("adjacent", 8'(bad), 8'd0);
         if (r && k == n) check("rdata", rdata, din);
         prev = cur;
         psg_din = (exp == 2'b01) ? din : 8'h5A;
         if (k < n) step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] codes_b;
      logic [1:0]  e;
      rst_n = 1'b0; req = 1'b0; rnw = 1'b0; addr = 4'h0; wdata = 8'h00; psg_din = 8'h00;
      req_b = 1'b0; rnw_b = 1'b0; addr_b = 4'h0; wdata_b = 8'h00; psg_din_b = 8'h00;
      repeat (3) step();
      check("rst_ready", 8'(ready), 8'd0);
      check("rst_code", 8'({bdir, bc1}), 8'd0);
      check("rst_dout", bus_dout, 8'h00);
      check("rst_rdata", rdata, 8'h00);
      check("rst_rdv", 8'(rd_valid), 8'd0);
      rst_n = 1'b1;
      step();
      check("ready_after_rst", 8'(ready), 8'd1);
      check("ready_b_after_rst", 8'(ready_b), 8'd1);

      txn(1'b0, 4'h7, 8'h38, 8'h00, C_WR_FULL, 6, 1'b0);
      txn(1'b1, 4'h0, 8'h00, 8'hA5, C_RD_FULL, 6, 1'b0);

      // req held across transactions with alternating direction
      txn(1'b0, 4'h1, 8'h11, 8'h00, C_WR_FULL, 6, 1'b1);
      txn(1'b1, 4'h2, 8'h00, 8'h3C, C_RD_FULL, 6, 1'b1);
      txn(1'b0, 4'h3, 8'hC3, 8'h00, C_WR_FULL, 6, 1'b1);
      txn(1'b1, 4'h4, 8'h00, 8'h96, C_RD_FULL, 6, 1'b0);
      step();
      check("idle_ready", 8'(ready), 8'd1);
      check("idle_rdata", rdata, 8'h96);

      // Reset during the first RD cycle of a read
      req = 1'b1; rnw = 1'b1; addr = 4'h0; psg_din = 8'h77;
      step();
      req = 1'b0;
      repeat (3) step();
      check("mid_code_rd", 8'({bdir, bc1}), 8'b01);
      rst_n = 1'b0;
      step();
      check("mid_code", 8'({bdir, bc1}), 8'd0);
      check("mid_ready", 8'(ready), 8'd0);
      check("mid_rdata", rdata, 8'h00);
      check("mid_rdv", 8'(rd_valid), 8'd0);
      rst_n = 1'b1;
      step();
      check("mid_ready_back", 8'(ready), 8'd1);
      check("mid_rdv_back", 8'(rd_valid), 8'd0);
      check("mid_code_back", 8'({bdir, bc1}), 8'd0);
      step();
      check("mid_rdv_late", 8'(rd_valid), 8'd0);

      // HOLD=1, GAP=3 instance: 11,00,10,00,00,00 with ready at t0+6
      codes_b = 16'b0000_00_00_00_10_00_11;
      check("b_ready_pre", 8'(ready_b), 8'd1);
      req_b = 1'b1; rnw_b = 1'b0; addr_b = 4'h3; wdata_b = 8'h5C;
      step();
      req_b = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         e = codes_b[2*(k-1) +: 2];
         check("b_code", 8'({bdir_b, bc1_b}), 8'(e));
         check("b_ready", 8'(ready_b), 8'(k == 6));
         if (e == 2'b11) check("b_dout_addr", bus_dout_b, 8'h03);
         if (e == 2'b10) check("b_dout_wr", bus_dout_b, 8'h5C);
         if (k < 6) step();
      end

      txn(1'b0, 4'h8, 8'h81, 8'h00, C_WR_FULL, 6, 1'b0);
`ifdef JT49_ADDR_CACHE_EN
      txn(1'b0, 4'h8, 8'h82, 8'h00, C_WR_HIT, 3, 1'b0);
`else
      txn(1'b0, 4'h8, 8'h82, 8'h00, C_WR_FULL, 6, 1'b0);
`endif
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      txn(1'b0, 4'h8, 8'h83, 8'h00, C_WR_FULL, 6, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
